wr_ctrl: RTL

- Write-side controller for the capture path; counterpart of the read controller that fills the capture FIFO.
- Pops 32-bit words from the capture FIFO and writes them to a host-memory ring buffer through an Avalon-MM write master on the F2H bridge.
- Single-beat writes; ring base address and size come from the control registers.
- Tracks the host's read index so unread data is never overwritten.

---
 rtl/wr_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wr_ctrl
// Purpose  : Write-side controller of the capture path. Pops 32-bit words from
//            the capture FIFO (non-show-ahead) and writes each one as a
//            single-beat Avalon-MM write into a host-memory ring buffer. The
//            host read index is tracked so unread data is never overwritten;
//            one ring slot always stays empty.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            enable               - run (1) / finish current word then idle (0)
//            base_addr/ring_words - ring geometry, latched on IDLE->FETCH
//            host_rd_idx          - next index the host will read
//            fifo_*               - capture FIFO read side
//            avm_*                - Avalon-MM write master
//            wr_idx, wrap_cnt     - ring write index, saturating wrap counter
//            busy, ring_full      - status
//            wm_words, irq_ack, irq (WR_CTRL_WATERMARK_EN only) - sticky
//                                   watermark interrupt on written words
// Options  : `define WR_CTRL_WATERMARK_EN to build the watermark interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wr_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [IDX_W-1:0]    ring_words,
  input  logic [IDX_W-1:0]    host_rd_idx,
  input  logic [DATA_W-1:0]   fifo_out,
  input  logic                fifo_empty,
  output logic                fifo_rdreq,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
`ifdef WR_CTRL_WATERMARK_EN
  input  logic [IDX_W-1:0]    wm_words,
  input  logic                irq_ack,
  output logic                irq,
`endif
  output logic [IDX_W-1:0]    wr_idx,
  output logic [15:0]         wrap_cnt,
  output logic                busy,
  output logic                ring_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LATCH = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  ring_q;

  logic [IDX_W-1:0]  next_idx;
  logic              at_last;
  logic              full;
  logic              accept;
  logic [ADDR_W-1:0] idx_off;

  // Index arithmetic always uses the geometry latched at start, so host-side
  // register changes while busy cannot corrupt an active ring.
  assign at_last  = (wr_idx == ring_q - IDX_W'(1));
  assign next_idx = at_last ? '0 : wr_idx + IDX_W'(1);
  assign full     = (next_idx == host_rd_idx);
  assign idx_off  = ADDR_W'(wr_idx) << 2;

  // avm_write is always 1 in S_WRITE, so acceptance only needs the stall.
  assign accept     = (state == S_WRITE) && !avm_waitrequest;
  assign fifo_rdreq = (state == S_FETCH) && enable && !full && !fifo_empty;
  assign ring_full  = (state == S_FETCH) && enable && full;
  assign busy       = (state != S_IDLE);

  // wr_idx is only cleared by reset, so the first start after reset begins at
  // slot 0 while later enable toggles resume where the ring left off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base_q         <= '0;
      ring_q         <= '0;
      wr_idx         <= '0;
      wrap_cnt       <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            base_q <= base_addr;
            ring_q <= ring_words;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (fifo_rdreq) begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          // FIFO data is valid one cycle after the pop.
          avm_writedata  <= fifo_out;
          avm_address    <= base_q + idx_off;
          avm_write      <= 1'b1;
          avm_byteenable <= '1;
          state          <= S_WRITE;
        end
        S_WRITE: begin
          if (accept) begin
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            wr_idx         <= next_idx;
            if (at_last && (wrap_cnt != 16'hFFFF)) begin
              wrap_cnt <= wrap_cnt + 16'd1;
            end
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WR_CTRL_WATERMARK_EN
  logic [IDX_W-1:0] pending;
  logic [IDX_W-1:0] pending_nxt;

  // An ack wipes the history, but a write accepted in the same cycle still
  // counts as the first word of the new window.
  always_comb begin
    pending_nxt = pending;
    if (irq_ack) begin
      pending_nxt = accept ? IDX_W'(1) : '0;
    end else if (accept && (pending != '1)) begin
      pending_nxt = pending + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (irq_ack) begin
        irq <= 1'b0;
      end else if ((wm_words != '0) && (pending_nxt >= wm_words)) begin
        irq <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
